hidden_out_serializer: RTL and testbench

HIDDEN_OUT_SERIALIZER -- requirements
Module: hidden_out_serializer

---
 rtl/hidden_out_serializer.sv | 131 +++++++++++++
 tb/tb_hidden_out_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hidden_out_serializer.sv
// Collects one activation per hidden neuron into a slot buffer, then streams the
// slots out in index order as DATA_W beats with last/index sideband.
module hidden_out_serializer #(
   parameter int NUM_NEURON = 64,
   parameter int DATA_W     = 16,
   parameter int IDX_W      = $clog2(NUM_NEURON)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_NEURON*DATA_W-1:0] neuron_out,
   input  logic [NUM_NEURON-1:0]        neuron_valid,
   input  logic                         clear_err,
   output logic [DATA_W-1:0]            m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_last,
   output logic [IDX_W-1:0]             m_index,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         overflow,
   output logic [1:0]                   state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      STREAM  = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [DATA_W-1:0]       slot [NUM_NEURON];
   logic [NUM_NEURON-1:0]   cap, cap_next;
   logic [IDX_W-1:0]        index, index_next;
   logic                    m_valid_next;
   logic                    frame_done_next;
   logic                    capture_en;
   logic                    xfer;
   logic                    last_beat;

   // Handshake: a beat transfers on a rising edge where m_valid & m_ready; while
   // m_valid is high and m_ready low, m_data/m_index/m_last hold. m_valid only
   // depends on registered state, never combinationally on m_ready.
   assign xfer       = m_valid & m_ready;
   assign last_beat  = (index == IDX_W'(NUM_NEURON - 1));
   assign capture_en = (state != STREAM);

   assign m_data    = slot[index];
   assign m_index   = index;
   assign m_last    = m_valid & last_beat;
   assign state_dbg = state;

   always_comb begin
      state_next      = state;
      cap_next        = cap;
      index_next      = index;
      m_valid_next    = m_valid;
      frame_done_next = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            cap_next = cap | neuron_valid;
            if (&cap_next) begin
               state_next   = STREAM;
               index_next   = '0;
               m_valid_next = 1'b1;
            end else if (|neuron_valid) begin
               state_next = COLLECT;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (last_beat) begin
                  state_next      = IDLE;
                  m_valid_next    = 1'b0;
                  cap_next        = '0;
                  index_next      = '0;
                  frame_done_next = 1'b1;
               end else begin
                  index_next = index + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next   = IDLE;
            cap_next     = '0;
            index_next   = '0;
            m_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cap        <= '0;
         index      <= '0;
         m_valid    <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         cap        <= cap_next;
         index      <= index_next;
         m_valid    <= m_valid_next;
         frame_done <= frame_done_next;
         busy       <= (state_next != IDLE);
      end
   end

   // Latest capture wins; slots are frozen while streaming.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURON; i++) slot[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_NEURON; i++) begin
            if (capture_en && neuron_valid[i]) slot[i] <= neuron_out[i*DATA_W +: DATA_W];
         end
      end
   end

   // A new overflow event takes priority over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (state == STREAM && (|neuron_valid)) begin
         overflow <= 1'b1;
      end else if (clear_err) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hidden_out_serializer.sv
// Directed bench for hidden_out_serializer with NUM_NEURON=4: frame capture,
// staggered/duplicate captures, back-pressure, overflow and mid-frame reset.
module tb_hidden_out_serializer;

   localparam int NUM_NEURON = 4;
   localparam int DATA_W     = 16;
   localparam int IDX_W      = 2;
   localparam int W          = IDX_W + DATA_W;

   logic                         clk;
   logic                         rst;
   logic [NUM_NEURON*DATA_W-1:0] neuron_out;
   logic [NUM_NEURON-1:0]        neuron_valid;
   logic                         clear_err;
   logic [DATA_W-1:0]            m_data;
   logic                         m_valid;
   logic                         m_ready;
   logic                         m_last;
   logic [IDX_W-1:0]             m_index;
   logic                         busy;
   logic                         frame_done;
   logic                         overflow;
   logic [1:0]                   state_dbg;

   logic [W-1:0] exp_q[$];
   int           checks;
   int           errors;

   hidden_out_serializer #(
      .NUM_NEURON(NUM_NEURON),
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .neuron_out  (neuron_out),
      .neuron_valid(neuron_valid),
      .clear_err   (clear_err),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .m_index     (m_index),
      .busy        (busy),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle_valid(input logic [NUM_NEURON-1:0] mask, input logic [NUM_NEURON*DATA_W-1:0] data);
      neuron_out   = data;
      neuron_valid = mask;
      tick();
      neuron_valid = '0;
   endtask

   task automatic push_exp(input int idx, input logic [DATA_W-1:0] data);
      exp_q.push_back({IDX_W'(idx), data});
   endtask

   task automatic wait_done(input string tag, input int budget);
      int  n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (frame_done) seen = 1'b1;
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   // scoreboard: every transfer must match the head of exp_q
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("extra_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("beat_data", 32'(m_data), 32'(e[DATA_W-1:0]));
            check_eq("beat_index", 32'(m_index), 32'(e[W-1:DATA_W]));
            check_eq("beat_last", 32'(m_last), 32'(e[W-1:DATA_W] == IDX_W'(NUM_NEURON - 1)));
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] vals [NUM_NEURON];
      logic [3:0]        pat;
      int                beats;
      int                i;

      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      neuron_out   = '0;
      neuron_valid = '0;
      clear_err    = 1'b0;
      m_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_frame_done", 32'(frame_done), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_m_index", 32'(m_index), 32'd0);
      check_eq("rst_m_last", 32'(m_last), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      tick();

      // all valids at once, back-to-back beats
      m_ready = 1'b1;
      push_exp(0, 16'h0010); push_exp(1, 16'h0020); push_exp(2, 16'h0030); push_exp(3, 16'h0040);
      cycle_valid(4'b1111, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
      check_eq("t1_state_stream", 32'(state_dbg), 32'd2);
      check_eq("t1_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check_eq("t1_m_valid", 32'(m_valid), 32'd1);
         check_eq("t1_m_index", 32'(m_index), 32'(k));
         check_eq("t1_m_last", 32'(m_last), 32'(k == 3));
         tick();
      end
      check_eq("t1_frame_done", 32'(frame_done), 32'd1);
      check_eq("t1_m_valid_low", 32'(m_valid), 32'd0);
      check_eq("t1_state_idle", 32'(state_dbg), 32'd0);
      tick();
      check_eq("t1_frame_done_pulse", 32'(frame_done), 32'd0);
      check_eq("t1_busy_low", 32'(busy), 32'd0);

      // staggered captures
      push_exp(0, 16'h0A01); push_exp(1, 16'h0A02); push_exp(2, 16'h0A03); push_exp(3, 16'h0A04);
      cycle_valid(4'b0001, {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01});
      check_eq("t2_busy_c1", 32'(busy), 32'd1);
      check_eq("t2_state_collect", 32'(state_dbg), 32'd1);
      tick();
      tick();
      cycle_valid(4'b0100, {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01});
      check_eq("t2_still_collect", 32'(state_dbg), 32'd1);
      check_eq("t2_no_valid", 32'(m_valid), 32'd0);
      tick();
      cycle_valid(4'b1010, {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01});
      check_eq("t2_state_stream", 32'(state_dbg), 32'd2);
      check_eq("t2_first_data", 32'(m_data), 32'h0A01);
      wait_done("t2_done", 10);
      tick();

      // duplicate capture on slot 1, latest wins
      push_exp(0, 16'h0B01); push_exp(1, 16'h0022); push_exp(2, 16'h0B03); push_exp(3, 16'h0B04);
      cycle_valid(4'b0010, {16'h0000, 16'h0000, 16'h0011, 16'h0000});
      cycle_valid(4'b0010, {16'h0000, 16'h0000, 16'h0022, 16'h0000});
      check_eq("t3_collect", 32'(state_dbg), 32'd1);
      cycle_valid(4'b1101, {16'h0B04, 16'h0B03, 16'h0055, 16'h0B01});
      wait_done("t3_done", 10);
      tick();

      // back-pressure with m_ready pattern 1,0,0,1
      m_ready = 1'b0;
      vals[0] = 16'h0C01; vals[1] = 16'h0C02; vals[2] = 16'h0C03; vals[3] = 16'h0C04;
      for (int k = 0; k < 4; k++) push_exp(k, vals[k]);
      cycle_valid(4'b1111, {vals[3], vals[2], vals[1], vals[0]});
      pat   = 4'b1001;
      beats = 0;
      i     = 0;
      while (beats < 4 && i < 40) begin
         check_eq("t4_m_valid", 32'(m_valid), 32'd1);
         check_eq("t4_m_index", 32'(m_index), 32'(beats));
         check_eq("t4_m_data", 32'(m_data), 32'(vals[beats]));
         check_eq("t4_m_last", 32'(m_last), 32'(beats == 3));
         m_ready = pat[i % 4];
         tick();
         if (m_ready) beats++;
         i++;
      end
      check_eq("t4_beats", 32'(beats), 32'd4);
      check_eq("t4_frame_done", 32'(frame_done), 32'd1);
      check_eq("t4_m_valid_low", 32'(m_valid), 32'd0);
      m_ready = 1'b1;
      tick();

      // overflow while streaming, clear priority, then clear
      m_ready = 1'b0;
      push_exp(0, 16'h0D01); push_exp(1, 16'h0D02); push_exp(2, 16'h0D03); push_exp(3, 16'h0D04);
      cycle_valid(4'b1111, {16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01});
      check_eq("t5_no_overflow", 32'(overflow), 32'd0);
      cycle_valid(4'b0001, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD});
      check_eq("t5_overflow_set", 32'(overflow), 32'd1);
      check_eq("t5_data_kept", 32'(m_data), 32'h0D01);
      clear_err = 1'b1;
      cycle_valid(4'b0001, {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF});
      clear_err = 1'b0;
      check_eq("t5_overflow_wins", 32'(overflow), 32'd1);
      m_ready = 1'b1;
      wait_done("t5_done", 10);
      check_eq("t5_overflow_sticky", 32'(overflow), 32'd1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check_eq("t5_overflow_clear", 32'(overflow), 32'd0);

      // reset after 2nd beat aborts the frame
      push_exp(0, 16'h0E01); push_exp(1, 16'h0E02);
      cycle_valid(4'b1111, {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01});
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      check_eq("t6_rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_state", 32'(state_dbg), 32'd0);
      check_eq("t6_rst_m_index", 32'(m_index), 32'd0);
      check_eq("t6_rst_m_data", 32'(m_data), 32'd0);
      tick();
      rst = 1'b0;
      push_exp(0, 16'h0100); push_exp(1, 16'h0200); push_exp(2, 16'h0300); push_exp(3, 16'h0400);
      cycle_valid(4'b0001, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
      check_eq("t6_empty_mask", 32'(state_dbg), 32'd1);
      check_eq("t6_no_beat", 32'(m_valid), 32'd0);
      cycle_valid(4'b1110, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
      check_eq("t6_stream", 32'(state_dbg), 32'd2);
      check_eq("t6_first_data", 32'(m_data), 32'h0100);
      wait_done("t6_done", 10);
      tick();
      tick();

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
